m_axi_read_arb: RTL and testbench
=================================

# m_axi_read_arb

- Shares one AXI read master core-side interface between `NUM_CLIENTS` requesters.
- Arbitrates read requests and forwards the winner's address, len, size and burst to the master.
- Records each issued client ID in order and steers the in-order read data beats back to that client until its last beat.
- Sits between the socket's DMA/load clients and the AXI read master.

## Interface
Parameters:
- `NUM_CLIENTS`, 4, number of requesters (2..8).
- `AXI_AWIDTH`, 64, address width.
- `AXI_DWIDTH`, 256, data width.
- `ID_LOGDEPTH`, 2, log2 depth of the issued-ID ordering FIFO.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `cl_req_valid`  in  NUM_CLIENTS  per-client request valid.
- `cl_req_ready`  out  NUM_CLIENTS  per-client request accepted.
- `cl_req_addr`  in  NUM_CLIENTS*AXI_AWIDTH  packed addresses; client i at slice i.
- `cl_req_len`  in  NUM_CLIENTS*32  packed beat count minus 1.
- `cl_req_size`  in  NUM_CLIENTS*3  packed size.
- `cl_req_burst`  in  NUM_CLIENTS*2  packed burst.
- `cl_data`  out  AXI_DWIDTH  read data, broadcast to all clients.
- `cl_data_valid`  out  NUM_CLIENTS  per-client data valid.
- `cl_data_ready`  in  NUM_CLIENTS  per-client data ready.
- `cl_data_last`  out  NUM_CLIENTS  per-client last beat.
- `core_read_request_valid`/`_ready`  out/in  1  request handshake to the master.
- `core_read_addr`/`_len`/`_size`/`_burst`  out  AXI_AWIDTH/32/3/2  forwarded request fields.
- `core_read_data`  in  AXI_DWIDTH  data from the master.
- `core_read_data_valid`/`_ready`  in/out  1  data handshake with the master.
- `core_read_data_last`  in  1  last beat of a request.

## Operation
Request FSM, 2 states:
- ARB_IDLE:
  - When any `cl_req_valid` is set and the ID FIFO is not full, pick a winner.
  - Register the winner in `grant` (log2 NUM_CLIENTS bits) and go to ARB_REQ.
- ARB_REQ:
  - `core_read_request_valid` = `cl_req_valid[grant]`; request fields are the muxed `grant` slice.
  - `cl_req_ready[grant]` = `core_read_request_ready`; all other readies are 0.
  - On request fire: push `grant` into the ID FIFO, set rr pointer = `grant`+1 (mod NUM_CLIENTS), return to ARB_IDLE.
  - If the granted client drops valid before fire, return to ARB_IDLE without a push. This is illegal client behaviour, but it must not hang the block.

Clients hold valid and fields stable until ready (AXI rule).

Winner selection: lowest index at or after the rr pointer with valid set (see Configuration).

Data steering, using the FIFO head `hd` while the FIFO is non-empty:
- `cl_data_valid[hd]` = `core_read_data_valid`; all other bits 0.
- `core_read_data_ready` = `cl_data_ready[hd]`.
- `cl_data_last[hd]` = `core_read_data_valid & core_read_data_last`.
- Pop on `core_read_data_valid & core_read_data_ready & core_read_data_last`.
- FIFO empty: `core_read_data_ready`=0 and all `cl_data_valid`=0.

Requests and data overlap: a new request may issue while earlier data is still streaming. Ordering is preserved because the master returns data in issue order.

## Timing
- Reset state:
  - FSM = ARB_IDLE, `grant`=0, rr pointer=0, ID FIFO empty.
  - All `cl_req_ready`, `cl_data_valid`, `cl_data_last`, `core_read_request_valid` and `core_read_data_ready` read 0.
- Latency:
  - `cl_req_valid` rising in ARB_IDLE gives `core_read_request_valid` on the next cycle.
  - Minimum 2 cycles per accepted request (IDLE then REQ with ready=1).
- Data path is combinational; no added latency or buffering.
- FIFO full (2^ID_LOGDEPTH outstanding requests): no grant is made. A grant is made in the same cycle a pop frees an entry only from the following cycle, because the full flag is registered.
- A push and a pop in the same cycle are allowed; the count is unchanged.
- `rst` mid-transfer:
  - All state clears; in-flight IDs are discarded.
  - The AXI read master must be reset in the same cycle.
- Pointer and `grant` arithmetic wrap modulo NUM_CLIENTS; a non-power-of-2 NUM_CLIENTS wraps explicitly to 0.

## Configuration
- `M_AXI_READ_ARB_RR_EN` defined: round-robin selection as above.
- Undefined: fixed priority. The lowest-index valid client always wins, and the rr pointer is neither used nor updated.

## Test plan
- Single client: client 2 requests addr 0x1000, len 3 → one master request (addr 0x1000, len 3); 4 beats appear on `cl_data_valid[2]` only; `cl_data_last[2]` is high on beat 4; FIFO ends empty.
- Contention: clients 0, 1, 3 assert together with `M_AXI_READ_ARB_RR_EN` → grant order 0, 1, 3, then 0 again if re-requested. Without the macro → order 0, 0, ... while client 0 keeps requesting.
- Overlap: client 0 len 7, then client 1 len 1 issued before client 0's last beat → client 1's 2 beats are routed only after client 0's 8th beat.
- Backpressure: `cl_data_ready[hd]`=0 for 5 cycles mid-burst → `core_read_data_ready`=0 for those cycles; no beat is lost or duplicated.
- FIFO full (ID_LOGDEPTH=2): 4 requests outstanding → a 5th request sees `cl_req_ready` stay 0 until the first request's last beat pops.
- Reset mid-burst: assert `rst` on beat 2 of 4 → all outputs 0 on the next cycle; a fresh request afterwards is granted to the rr-pointer-0 winner.

Source files
------------

// File: rtl/m_axi_read_arb.sv
// m_axi_read_arb: shares one AXI read master core-side port between NUM_CLIENTS
// requesters. One request is granted at a time. Each issued client ID goes into an
// in-order FIFO, and that FIFO steers the returning read beats to their client.
// Optional feature: define M_AXI_READ_ARB_RR_EN to get round-robin selection.
// When it is undefined, selection is fixed priority (lowest index wins).
module m_axi_read_arb #(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned AXI_AWIDTH  = 64,
  parameter int unsigned AXI_DWIDTH  = 256,
  parameter int unsigned ID_LOGDEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            cl_req_valid,
  output logic [NUM_CLIENTS-1:0]            cl_req_ready,
  input  logic [NUM_CLIENTS*AXI_AWIDTH-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS*32-1:0]         cl_req_len,
  input  logic [NUM_CLIENTS*3-1:0]          cl_req_size,
  input  logic [NUM_CLIENTS*2-1:0]          cl_req_burst,
  output logic [AXI_DWIDTH-1:0]             cl_data,
  output logic [NUM_CLIENTS-1:0]            cl_data_valid,
  input  logic [NUM_CLIENTS-1:0]            cl_data_ready,
  output logic [NUM_CLIENTS-1:0]            cl_data_last,
  output logic                              core_read_request_valid,
  input  logic                              core_read_request_ready,
  output logic [AXI_AWIDTH-1:0]             core_read_addr,
  output logic [31:0]                       core_read_len,
  output logic [2:0]                        core_read_size,
  output logic [1:0]                        core_read_burst,
  input  logic [AXI_DWIDTH-1:0]             core_read_data,
  input  logic                              core_read_data_valid,
  output logic                              core_read_data_ready,
  input  logic                              core_read_data_last
);

  localparam int unsigned GW    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned DEPTH = 1 << ID_LOGDEPTH;
  localparam int unsigned CW    = ID_LOGDEPTH + 1;

  typedef enum logic {ARB_IDLE, ARB_REQ} arb_state_e;

  arb_state_e              state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
`ifdef M_AXI_READ_ARB_RR_EN
  logic [GW-1:0]           rr_q, rr_d;
  int unsigned             cand;
  logic [GW-1:0]           cand_g;
`endif
  logic [GW-1:0]           winner;
  logic                    any_valid;
  logic                    push, pop;

  logic [GW-1:0]           id_mem [DEPTH];
  logic [ID_LOGDEPTH-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           count_q, count_d;
  logic                    full_q, empty;
  logic [GW-1:0]           hd;

  logic [AXI_AWIDTH-1:0]   addr_arr  [NUM_CLIENTS];
  logic [31:0]             len_arr   [NUM_CLIENTS];
  logic [2:0]              size_arr  [NUM_CLIENTS];
  logic [1:0]              burst_arr [NUM_CLIENTS];

  // Unpack per-client request fields
  for (genvar i = 0; i < int'(NUM_CLIENTS); i++) begin : g_slice
    assign addr_arr[i]  = cl_req_addr[i*AXI_AWIDTH +: AXI_AWIDTH];
    assign len_arr[i]   = cl_req_len[i*32 +: 32];
    assign size_arr[i]  = cl_req_size[i*3 +: 3];
    assign burst_arr[i] = cl_req_burst[i*2 +: 2];
  end

  // Forwarded request fields follow the current grant
  assign core_read_addr  = addr_arr[grant_q];
  assign core_read_len   = len_arr[grant_q];
  assign core_read_size  = size_arr[grant_q];
  assign core_read_burst = burst_arr[grant_q];
  assign cl_data         = core_read_data;

  // Winner selection: round-robin from rr pointer, or fixed lowest-index priority
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
`ifdef M_AXI_READ_ARB_RR_EN
    cand      = 0;
    cand_g    = '0;
    for (int unsigned k = 0; k < NUM_CLIENTS; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      cand_g = GW'(cand);
      if (!any_valid && cl_req_valid[cand_g]) begin
        any_valid = 1'b1;
        winner    = cand_g;
      end
    end
`else
    for (int k = int'(NUM_CLIENTS) - 1; k >= 0; k--) begin
      if (cl_req_valid[k]) begin
        any_valid = 1'b1;
        winner    = GW'(k);
      end
    end
`endif
  end

  // Request FSM state, grant and rr pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
`ifdef M_AXI_READ_ARB_RR_EN
      rr_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
`ifdef M_AXI_READ_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Request FSM next-state and request-side handshake outputs
  always_comb begin
    state_d                 = state_q;
    grant_d                 = grant_q;
`ifdef M_AXI_READ_ARB_RR_EN
    rr_d                    = rr_q;
`endif
    push                    = 1'b0;
    cl_req_ready            = '0;
    core_read_request_valid = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (any_valid && !full_q) begin
          grant_d = winner;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        core_read_request_valid = cl_req_valid[grant_q];
        cl_req_ready[grant_q]   = core_read_request_ready;
        if (!cl_req_valid[grant_q]) begin
          // Granted client withdrew; drop the grant rather than hang
          state_d = ARB_IDLE;
        end else if (core_read_request_ready) begin
          push    = 1'b1;
          state_d = ARB_IDLE;
`ifdef M_AXI_READ_ARB_RR_EN
          rr_d    = (grant_q == GW'(NUM_CLIENTS - 1)) ? '0 : grant_q + GW'(1);
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign empty   = (count_q == '0);
  assign hd      = id_mem[rd_ptr_q];
  assign count_d = count_q + CW'(push) - CW'(pop);

  // Issued-ID storage (no reset needed; validity tracked by count)
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= grant_q;
  end

  // ID FIFO pointers, occupancy and registered full flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ID_LOGDEPTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ID_LOGDEPTH'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
    end
  end

  // Steer in-order read beats to the client at the FIFO head
  always_comb begin
    cl_data_valid        = '0;
    cl_data_last         = '0;
    core_read_data_ready = 1'b0;
    pop                  = 1'b0;
    if (!empty) begin
      cl_data_valid[hd]    = core_read_data_valid;
      cl_data_last[hd]     = core_read_data_valid & core_read_data_last;
      core_read_data_ready = cl_data_ready[hd];
      pop = core_read_data_valid & cl_data_ready[hd] & core_read_data_last;
    end
  end

endmodule

// File: tb/tb_m_axi_read_arb.sv
// Scoreboard bench for m_axi_read_arb: client drivers and a read-master model run
// on the falling edge, and a monitor pops expected requests and beats on handshakes.
module tb_m_axi_read_arb;
  localparam int NC = 4;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int LD = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NC-1:0]     cl_req_valid;
  logic [NC-1:0]     cl_req_ready;
  logic [NC*AW-1:0]  cl_req_addr;
  logic [NC*32-1:0]  cl_req_len;
  logic [NC*3-1:0]   cl_req_size;
  logic [NC*2-1:0]   cl_req_burst;
  logic [DW-1:0]     cl_data;
  logic [NC-1:0]     cl_data_valid;
  logic [NC-1:0]     cl_data_ready;
  logic [NC-1:0]     cl_data_last;
  logic              core_read_request_valid;
  logic              core_read_request_ready;
  logic [AW-1:0]     core_read_addr;
  logic [31:0]       core_read_len;
  logic [2:0]        core_read_size;
  logic [1:0]        core_read_burst;
  logic [DW-1:0]     core_read_data;
  logic              core_read_data_valid;
  logic              core_read_data_ready;
  logic              core_read_data_last;

  m_axi_read_arb #(.NUM_CLIENTS(NC), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW), .ID_LOGDEPTH(LD)) dut (
    .clk(clk), .rst(rst),
    .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready),
    .cl_req_addr(cl_req_addr), .cl_req_len(cl_req_len),
    .cl_req_size(cl_req_size), .cl_req_burst(cl_req_burst),
    .cl_data(cl_data), .cl_data_valid(cl_data_valid),
    .cl_data_ready(cl_data_ready), .cl_data_last(cl_data_last),
    .core_read_request_valid(core_read_request_valid),
    .core_read_request_ready(core_read_request_ready),
    .core_read_addr(core_read_addr), .core_read_len(core_read_len),
    .core_read_size(core_read_size), .core_read_burst(core_read_burst),
    .core_read_data(core_read_data), .core_read_data_valid(core_read_data_valid),
    .core_read_data_ready(core_read_data_ready), .core_read_data_last(core_read_data_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } req_t;

  typedef struct {
    int            client;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  req_t  exp_req[$];
  beat_t exp_beat[$];
  req_t  cl_q[NC][$];
  req_t  m_q[$];

  int total = 0;
  int bad = 0;
  int req_seen = 0;
  int beats_seen = 0;
  logic m_data_en = 1'b1;

  function automatic logic [DW-1:0] beat_data(logic [AW-1:0] a, int b);
    return {a, 32'(b), a ^ 64'hDEAD_BEEF_0123_4567, 96'(b * 3 + 1)};
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic issue(int c, logic [AW-1:0] a, logic [31:0] l, logic [2:0] s, logic [1:0] b);
    req_t r;
    r.addr = a; r.len = l; r.size = s; r.burst = b;
    cl_q[c].push_back(r);
  endtask

  task automatic expect_req(int c, logic [AW-1:0] a, logic [31:0] l, logic [2:0] s, logic [1:0] b);
    req_t  r;
    beat_t e;
    r.addr = a; r.len = l; r.size = s; r.burst = b;
    exp_req.push_back(r);
    for (int i = 0; i <= int'(l); i++) begin
      e.client = c;
      e.data   = beat_data(a, i);
      e.last   = (i == int'(l));
      exp_beat.push_back(e);
    end
  endtask

  task automatic wait_reqs(int target);
    int n = 0;
    while (req_seen < target && n < 500) begin
      @(negedge clk); #2; n++;
    end
    total++;
    if (req_seen < target) begin
      bad++;
      $display("FAIL wait_reqs: seen %0d required %0d", req_seen, target);
    end
  endtask

  task automatic wait_beats(int target);
    int n = 0;
    while (beats_seen < target && n < 500) begin
      @(negedge clk); #2; n++;
    end
    total++;
    if (beats_seen < target) begin
      bad++;
      $display("FAIL wait_beats: seen %0d required %0d", beats_seen, target);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_beat.size() != 0 || exp_req.size() != 0) && n < 1000) begin
      @(negedge clk); #2; n++;
    end
    total++;
    if (exp_beat.size() != 0 || exp_req.size() != 0) begin
      bad++;
      $display("FAIL wait_idle: pending reqs %0d beats %0d required 0", exp_req.size(), exp_beat.size());
    end
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_req.delete();
    exp_beat.delete();
  endtask

  // Client drivers: hold valid and fields until accepted, then load the next request
  initial begin
    req_t cur[NC];
    bit   busy[NC];
    bit   fired[NC];
    cl_req_valid = '0; cl_req_addr = '0; cl_req_len = '0;
    cl_req_size = '0; cl_req_burst = '0;
    for (int c = 0; c < NC; c++) begin busy[c] = 1'b0; fired[c] = 1'b0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if (fired[c]) busy[c] = 1'b0;
        if (!busy[c] && cl_q[c].size() > 0) begin
          cur[c]  = cl_q[c].pop_front();
          busy[c] = 1'b1;
        end
        cl_req_valid[c]         = busy[c];
        cl_req_addr[c*AW +: AW] = cur[c].addr;
        cl_req_len[c*32 +: 32]  = cur[c].len;
        cl_req_size[c*3 +: 3]   = cur[c].size;
        cl_req_burst[c*2 +: 2]  = cur[c].burst;
      end
      #1;
      for (int c = 0; c < NC; c++) fired[c] = cl_req_valid[c] & cl_req_ready[c] & !rst;
    end
  end

  // Read master model: accepts requests, returns beats in issue order
  initial begin
    req_t nr;
    int   m_idx = 0;
    bit   m_req_fire = 1'b0;
    bit   m_beat_fire = 1'b0;
    bit   m_rst_seen = 1'b1;
    core_read_request_ready = 1'b1;
    core_read_data_valid = 1'b0;
    core_read_data = '0;
    core_read_data_last = 1'b0;
    forever begin
      @(negedge clk);
      if (m_rst_seen) begin
        m_q.delete();
        m_idx = 0;
      end else begin
        if (m_beat_fire) begin
          if (m_idx == int'(m_q[0].len)) begin
            void'(m_q.pop_front());
            m_idx = 0;
          end else begin
            m_idx++;
          end
        end
        if (m_req_fire) m_q.push_back(nr);
      end
      if (m_data_en && m_q.size() > 0) begin
        core_read_data_valid = 1'b1;
        core_read_data       = beat_data(m_q[0].addr, m_idx);
        core_read_data_last  = (m_idx == int'(m_q[0].len));
      end else begin
        core_read_data_valid = 1'b0;
        core_read_data       = '0;
        core_read_data_last  = 1'b0;
      end
      #1;
      m_req_fire  = core_read_request_valid & core_read_request_ready & !rst;
      nr.addr = core_read_addr; nr.len = core_read_len;
      nr.size = core_read_size; nr.burst = core_read_burst;
      m_beat_fire = core_read_data_valid & core_read_data_ready & !rst;
      m_rst_seen  = rst;
    end
  end

  // Monitor: compare every request and data handshake against the scoreboard
  initial begin
    req_t  r;
    beat_t b;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (core_read_request_valid && core_read_request_ready) begin
          if (exp_req.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got addr %0h expected no request", core_read_addr);
          end else begin
            r = exp_req.pop_front();
            check("req_addr", DW'(core_read_addr), DW'(r.addr));
            check("req_len", DW'(core_read_len), DW'(r.len));
            check("req_size", DW'(core_read_size), DW'(r.size));
            check("req_burst", DW'(core_read_burst), DW'(r.burst));
          end
          req_seen++;
        end
        for (int c = 0; c < NC; c++) begin
          if (cl_data_valid[c] && cl_data_ready[c]) begin
            if (exp_beat.size() == 0) begin
              total++; bad++;
              $display("FAIL beat_unexpected: got client %0d expected no beat", c);
            end else begin
              b = exp_beat.pop_front();
              check("beat_client", DW'(c), DW'(b.client));
              check("beat_data", cl_data, b.data);
              check("beat_last", DW'(cl_data_last[c]), DW'(b.last));
              check("beat_onehot", DW'($countones(cl_data_valid)), DW'(1));
            end
            beats_seen++;
          end
        end
      end
    end
  end

  // Directed sequence
  initial begin
    int base_r;
    int base_b;
    cl_data_ready = '1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_req_ready", DW'(cl_req_ready), DW'(0));
    check("rst_data_valid", DW'(cl_data_valid), DW'(0));
    check("rst_data_last", DW'(cl_data_last), DW'(0));
    check("rst_core_req_valid", DW'(core_read_request_valid), DW'(0));
    check("rst_core_data_ready", DW'(core_read_data_ready), DW'(0));
    @(negedge clk); rst = 1'b0;

    // Single client 2, 4 beats
    @(negedge clk);
    issue(2, 64'h1000, 32'd3, 3'd5, 2'd1);
    expect_req(2, 64'h1000, 32'd3, 3'd5, 2'd1);
    wait_idle();
    @(negedge clk); #2;
    check("single_fifo_empty", DW'(core_read_data_ready), DW'(0));

    // Contention from rr pointer 0
    reset_dut();
    issue(0, 64'h2000, 32'd1, 3'd5, 2'd1);
    issue(1, 64'h2100, 32'd1, 3'd4, 2'd0);
    issue(3, 64'h2300, 32'd1, 3'd3, 2'd2);
    issue(0, 64'h2040, 32'd1, 3'd5, 2'd1);
`ifdef M_AXI_READ_ARB_RR_EN
    expect_req(0, 64'h2000, 32'd1, 3'd5, 2'd1);
    expect_req(1, 64'h2100, 32'd1, 3'd4, 2'd0);
    expect_req(3, 64'h2300, 32'd1, 3'd3, 2'd2);
    expect_req(0, 64'h2040, 32'd1, 3'd5, 2'd1);
`else
    expect_req(0, 64'h2000, 32'd1, 3'd5, 2'd1);
    expect_req(0, 64'h2040, 32'd1, 3'd5, 2'd1);
    expect_req(1, 64'h2100, 32'd1, 3'd4, 2'd0);
    expect_req(3, 64'h2300, 32'd1, 3'd3, 2'd2);
`endif
    wait_idle();

    // Overlap: client 1 issues while client 0's burst streams
    base_r = req_seen; base_b = beats_seen;
    issue(0, 64'h4000, 32'd7, 3'd5, 2'd1);
    expect_req(0, 64'h4000, 32'd7, 3'd5, 2'd1);
    wait_reqs(base_r + 1);
    repeat (2) @(negedge clk);
    issue(1, 64'h4100, 32'd1, 3'd5, 2'd1);
    expect_req(1, 64'h4100, 32'd1, 3'd5, 2'd1);
    wait_reqs(base_r + 2);
    check("overlap_issued_early", DW'(beats_seen < base_b + 8), DW'(1));
    wait_idle();

    // Backpressure on the head client mid-burst
    base_b = beats_seen;
    issue(3, 64'h5000, 32'd7, 3'd5, 2'd1);
    expect_req(3, 64'h5000, 32'd7, 3'd5, 2'd1);
    wait_beats(base_b + 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cl_data_ready[3] = 1'b0;
      #2;
      check("bp_core_ready", DW'(core_read_data_ready), DW'(0));
      check("bp_valid_held", DW'(cl_data_valid[3]), DW'(1));
    end
    @(negedge clk); cl_data_ready = '1;
    wait_idle();

    // ID FIFO full: 4 outstanding, 5th waits for the first pop
    reset_dut();
    m_data_en = 1'b0;
    base_r = req_seen;
    for (int c = 0; c < NC; c++) begin
      issue(c, 64'h6000 + 64'(c) * 64'h100, 32'd1, 3'd5, 2'd1);
      expect_req(c, 64'h6000 + 64'(c) * 64'h100, 32'd1, 3'd5, 2'd1);
    end
    wait_reqs(base_r + 4);
    issue(1, 64'h6400, 32'd1, 3'd5, 2'd1);
    expect_req(1, 64'h6400, 32'd1, 3'd5, 2'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      check("full_no_grant", DW'({cl_req_ready, core_read_request_valid}), DW'(0));
    end
    base_b = beats_seen;
    m_data_en = 1'b1;
    wait_reqs(base_r + 5);
    check("full_grant_after_pop", DW'(beats_seen >= base_b + 2), DW'(1));
    wait_idle();

    // Reset mid-burst on beat 2 of 4, then a fresh contended request
    base_r = req_seen; base_b = beats_seen;
    issue(2, 64'h7000, 32'd3, 3'd5, 2'd1);
    expect_req(2, 64'h7000, 32'd3, 3'd5, 2'd1);
    wait_reqs(base_r + 1);
    wait_beats(base_b + 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_req.delete();
    exp_beat.delete();
    #2;
    check("midrst_outputs", DW'({cl_req_ready, cl_data_valid, cl_data_last,
                                 core_read_request_valid, core_read_data_ready}), DW'(0));
    issue(1, 64'h7100, 32'd1, 3'd5, 2'd1);
    issue(3, 64'h7300, 32'd1, 3'd5, 2'd1);
    expect_req(1, 64'h7100, 32'd1, 3'd5, 2'd1);
    expect_req(3, 64'h7300, 32'd1, 3'd5, 2'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    check("end_req_drained", DW'(exp_req.size()), DW'(0));
    check("end_beats_drained", DW'(exp_beat.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
